regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
Parametrised next-generation register file for the CPU datapath.
- Generalises register count, data width and PC width.
- Adds synchronous reset, a second write port for multi-cycle/load writeback, and same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards.
- Holds the architectural PC, with load and increment modes.

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 8, number of general registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register index width (derived; not overridden)
PC_W, 30, PC width (word address)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clk_en  in  1  gates register writes and scoreboard updates
wa_en  in  1  write port A enable (ALU writeback)
wa_reg  in  ADDR_W  write port A index
wa_val  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load/multi-cycle writeback)
wb_reg  in  ADDR_W  write port B index
wb_val  in  DATA_W  write port B data
issue_en  in  1  mark issue_reg pending
issue_reg  in  ADDR_W  destination of newly issued long-latency op
op1_reg  in  ADDR_W  read port 1 index
op2_reg  in  ADDR_W  read port 2 index
out1  out  DATA_W  read port 1 data
out2  out  DATA_W  read port 2 data
op1_busy  out  1  read port 1 register pending
op2_busy  out  1  read port 2 register pending
next_pc  in  PC_W  PC load value
write_pc  in  1  load PC from next_pc
pc_inc  in  1  PC <= PC + 1
pc  out  PC_W  current PC

Behaviour:
- Reset (rst=1 at a rising edge):
  - All registers become 0.
  - All pending bits are cleared.
  - pc becomes RESET_PC.
  - Reset overrides every other input, including clk_en.
- Register writes (when clk_en=1):
  - wa_en writes wa_val to wa_reg; wb_en writes wb_val to wb_reg.
  - If both target the same index, port B wins.
  - With clk_en=0, no register or pending bit changes.
- Reads are combinational.
  - outN = value being written this cycle if a qualifying write (enable & clk_en) targets opN_reg, with port B priority.
  - Otherwise outN = stored value.
  - Zero-latency bypass: the written value is visible on out1/out2 in the same cycle.
- Scoreboard: one pending bit per register.
  - Set: issue_en & clk_en sets pending[issue_reg].
  - Clear: wb_en & clk_en clears pending[wb_reg].
  - wa_en never affects pending.
  - Same cycle, same index, set and clear both active: set wins (bit stays 1, treated as a new pending op).
- Busy outputs:
  - opN_busy = pending[opN_reg] & ~(wb_en & clk_en & wb_reg==opN_reg).
  - A register being written back this cycle is reported not busy, consistent with the bypass.
- PC:
  - Priority: rst > write_pc > pc_inc > hold.
  - Not gated by clk_en.
  - Increment wraps modulo 2^PC_W.
- Out-of-range indices (NUM_REGS not a power of two) are not supported; indices always lie in 0..NUM_REGS-1.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to index 0 on either port are ignored.
  - Reads of index 0 return 0 (no bypass from writes).
  - pending[0] is never set; op busy for index 0 is always 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset: rst=1 for one edge after arbitrary writes and issues -> all regs read 0, op1_busy=op2_busy=0, pc=RESET_PC (0).
2. Bypass and write priority:
   - Step 1: clk_en=1, wa_en=1, wa_reg=3, wa_val=0x1234, op1_reg=3 -> out1=0x1234 same cycle, still 0x1234 after the edge.
   - Step 2: add wb_en=1, wb_reg=3, wb_val=0xBEEF -> out1=0xBEEF; stored value 0xBEEF.
3. Scoreboard:
   - Issue reg 5 -> op2_reg=5 gives op2_busy=1 from the next cycle.
   - wb_en with wb_reg=5, wb_val=7 -> op2_busy=0 and out2=7 in that cycle; pending cleared after the edge.
   - Simultaneous issue_en and wb_en on reg 5 -> op2_busy=1 after the edge.
4. clk_en=0 with wa_en=1, wa_reg=2, wa_val=0xFF and issue_en=1, issue_reg=2 -> reg 2 is unchanged and not pending after the edge; out1 shows the old value during the cycle (no bypass).
5. PC:
   - write_pc=1, next_pc=0x3FFFFFFF -> pc=0x3FFFFFFF.
   - Then pc_inc=1 -> pc=0 (wrap).
   - write_pc=1 with pc_inc=1 and next_pc=0x10 -> pc=0x10.
   - pc_inc=1 with clk_en=0 -> pc still increments.
6. With REGFILE_ZERO_REG_EN defined: wa_reg=0, wa_val=0xAAAA, issue_reg=0 -> out1 (op1_reg=0)=0 in the same cycle and after the edge; op1_busy=0.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-port register file with write-to-read bypass, RAW scoreboard and architectural PC.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_multiport #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        NUM_REGS = 8,
  parameter int unsigned        ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned        PC_W     = 30,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_reg,
  input  logic [DATA_W-1:0] wa_val,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_val,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] op1_reg,
  input  logic [ADDR_W-1:0] op2_reg,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              op1_busy,
  output logic              op2_busy,
  input  logic [PC_W-1:0]   next_pc,
  input  logic              write_pc,
  input  logic              pc_inc,
  output logic [PC_W-1:0]   pc
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [PC_W-1:0]     pc_q, pc_d;

  logic wa_ok, wb_ok, wb_clr, issue_ok;

`ifdef REGFILE_ZERO_REG_EN
  // Index 0 is never written or marked pending, so it stays at its reset value of zero.
  assign wa_ok    = wa_en & clk_en & (wa_reg != '0);
  assign wb_ok    = wb_en & clk_en & (wb_reg != '0);
  assign issue_ok = issue_en & clk_en & (issue_reg != '0);
`else
  assign wa_ok    = wa_en & clk_en;
  assign wb_ok    = wb_en & clk_en;
  assign issue_ok = issue_en & clk_en;
`endif
  assign wb_clr = wb_en & clk_en;

  always_comb begin
    regs_d = regs_q;
    if (wa_ok) regs_d[wa_reg] = wa_val;
    if (wb_ok) regs_d[wb_reg] = wb_val;
  end

  // Issue is applied after the clear so a same-index issue keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wb_clr)   pending_d[wb_reg]    = 1'b0;
    if (issue_ok) pending_d[issue_reg] = 1'b1;
  end

  always_comb begin
    pc_d = pc_q;
    if (write_pc)    pc_d = next_pc;
    else if (pc_inc) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      pending_q <= '0;
      pc_q      <= RESET_PC;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      pc_q      <= pc_d;
    end
  end

  // Next-state array doubles as the bypass network: port B priority falls out of write order.
  assign out1 = regs_d[op1_reg];
  assign out2 = regs_d[op2_reg];

  assign op1_busy = pending_q[op1_reg] & ~(wb_clr & (wb_reg == op1_reg));
  assign op2_busy = pending_q[op2_reg] & ~(wb_clr & (wb_reg == op2_reg));

  assign pc = pc_q;

endmodule
